word_bus_arbiter: RTL and testbench
===================================

Name: word_bus_arbiter

Overview:
- Shares one 32-bit result bus between two requesters, for example the ALU writeback and the load unit, each using a valid/ready handshake.
- Arbitrates round-robin and drives the select of a 2:1 word mux.
- Registers the chosen word into an output holding stage and holds it until the downstream consumer accepts it.
- Sits between the execution-side producers and the register-file write port.

Parameters:
- word_size, 32: width of each data word.
- count_width, 8: width of the completed-transfer counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req0  input  1  requester 0 has a valid word.
- data0  input  word_size  requester 0 word.
- grant0  output  1  combinational; transfer from requester 0 occurs this cycle when req0 & grant0.
- req1  input  1  requester 1 has a valid word.
- data1  input  word_size  requester 1 word.
- grant1  output  1  as grant0, for requester 1.
- out_valid  output  1  output holding register is full.
- out_data  output  word_size  held word.
- out_ready  input  1  consumer accepts out_data when out_valid & out_ready.
- sel  output  1  registered mux select; last winner.
- xfer_count  output  count_width  number of words accepted by the consumer.

Behaviour:
- Reset is asynchronous, active-low. While rst_n=0: out_valid=0, out_data=0, sel=0, xfer_count=0, internal last_served=1 (requester 0 wins the first tie), state=IDLE.
- grant0 and grant1 are 0 during reset. They are never both 1.
- States: IDLE (holding register empty) and FULL (holding register occupied).
- can_load = (state==IDLE) | (out_valid & out_ready).
- Winner:
  - only req0 → 0; only req1 → 1.
  - both → the requester != last_served.
  - none → no winner.
- grantN = can_load & (winner==N) & reqN. This is combinational and carries no state. Requesters must not wait on grant before asserting req.
- On the rising edge where a grant is high:
  - out_data <= data_winner, routed through the mux with select = winner.
  - out_valid <= 1; sel <= winner; last_served <= winner; state <= FULL.
  - Latency: the word is on out_data one cycle after the grant cycle.
- FULL with out_ready=0: out_data, out_valid and sel are held stable. No grants.
- FULL with out_ready=1:
  - xfer_count increments by 1, wrapping modulo 2^count_width (all-ones → 0).
  - If a winner exists, it loads back-to-back in the same edge and state stays FULL. This sustains one word per cycle.
  - Otherwise out_valid <= 0 and state <= IDLE. out_data keeps its last value.
- IDLE with out_ready=1: no effect and no count, because out_valid=0.
- A requester that holds req high across cycles is treated as a fresh request each cycle. Under continuous double request the grants alternate 0,1,0,1.
- A requester may drop req without having been granted; nothing is lost or latched.
- Reset mid-transfer: the held word is discarded immediately and the counter is cleared. Grants drop combinationally with rst_n low.
- Width rules:
  - data0, data1 and out_data are all exactly word_size; there is no extension or truncation.
  - xfer_count is unsigned and wraps silently.

Decomposition:
- Shared package / include holds:
  - state encoding constants ST_IDLE=1'b0 and ST_FULL=1'b1.
  - the requester index constants REQ0=0 and REQ1=1.
- Natural sub-module: instantiate the team's existing 2:1 word mux, mux_1bit, with word_size passed through, select = combinational winner. Its output feeds the out_data register.
- Arbitration and counter logic remain inline.

Test Plan:
- Reset check: hold rst_n=0 with req0=req1=1 and out_ready=1. Required: grant0=grant1=0, out_valid=0, out_data=0, sel=0, xfer_count=0. Release rst_n, then the first grant is grant0.
- Single requester: req0=1 with data0=32'hDEADBEEF for one cycle, out_ready=1. Required:
  - grant0=1 that cycle.
  - Next cycle out_valid=1, out_data=DEADBEEF, sel=0.
  - Cycle after, out_valid=0 and xfer_count=1.
- Backpressure: load data1=32'h0000_1234, hold out_ready=0 for 5 cycles while req0 is asserted. Required:
  - out_data stays 00001234.
  - grant0 stays 0 throughout.
  - On the out_ready=1 cycle, grant0=1 and next cycle out_data=data0.
- Fairness: req0=req1=1 continuously, out_ready=1, data0=A, data1=B. Required: grants alternate 0,1,0,1 from reset; out_data sequence is A,B,A,B at one word per cycle.
- Counter wrap: count_width=8, 256 accepted transfers. Required: xfer_count returns to 0 and no other output glitches.
- Async reset mid-FULL: assert rst_n=0 between clock edges while out_valid=1. Required: out_valid, out_data and xfer_count clear immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/word_bus_arbiter_pkg.sv
// Shared types and constants for the two-requester result-bus arbiter.
package word_bus_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FULL = 1'b1
  } state_e;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // Round-robin pick: a lone requester wins, a tie goes to the one not served last.
  function automatic logic pick_winner(input logic r0, input logic r1, input logic last);
    logic w;
    if (r0 && r1) begin
      w = ~last;
    end else if (r1) begin
      w = REQ1;
    end else begin
      w = REQ0;
    end
    return w;
  endfunction

endpackage

// File: rtl/mux_1bit.sv
// 2:1 word multiplexer with a single-bit select.
module mux_1bit #(
  parameter int unsigned word_size = 32
) (
  input  logic                 sel,
  input  logic [word_size-1:0] in0,
  input  logic [word_size-1:0] in1,
  output logic [word_size-1:0] out_word
);

  assign out_word = sel ? in1 : in0;

endmodule

// File: rtl/word_bus_arbiter.sv
// Round-robin arbiter sharing one result word bus between two valid/ready
// producers, with a single-entry output holding register and transfer counter.
module word_bus_arbiter
  import word_bus_arbiter_pkg::*;
#(
  parameter int unsigned word_size   = 32,
  parameter int unsigned count_width = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req0,
  input  logic [word_size-1:0]   data0,
  output logic                   grant0,
  input  logic                   req1,
  input  logic [word_size-1:0]   data1,
  output logic                   grant1,
  output logic                   out_valid,
  output logic [word_size-1:0]   out_data,
  input  logic                   out_ready,
  output logic                   sel,
  output logic [count_width-1:0] xfer_count
);

  state_e                 state_q, state_d;
  logic                   out_valid_q, out_valid_d;
  logic [word_size-1:0]   out_data_q, out_data_d;
  logic                   sel_q, sel_d;
  logic                   last_served_q, last_served_d;
  logic [count_width-1:0] xfer_count_q, xfer_count_d;

  logic                   can_load;
  logic                   accept;
  logic                   load;
  logic                   winner;
  logic [word_size-1:0]   mux_word;

  // Arbitration; gated by rst_n so grants drop the moment reset asserts.
  always_comb begin
    accept   = out_valid_q & out_ready;
    can_load = (state_q == ST_IDLE) | accept;
    winner   = pick_winner(req0, req1, last_served_q);
    load     = rst_n & can_load & (req0 | req1);
    grant0   = load & (winner == REQ0) & req0;
    grant1   = load & (winner == REQ1) & req1;
  end

  mux_1bit #(
    .word_size(word_size)
  ) u_word_mux (
    .sel     (winner),
    .in0     (data0),
    .in1     (data1),
    .out_word(mux_word)
  );

  always_comb begin
    state_d       = state_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    sel_d         = sel_q;
    last_served_d = last_served_q;
    xfer_count_d  = xfer_count_q;

    unique case (state_q)
      ST_IDLE: begin
        if (load) begin
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        // A back-to-back load keeps the stage full at one word per cycle.
        if (accept && !load) begin
          state_d = ST_IDLE;
        end
      end
    endcase

    if (load) begin
      out_data_d    = mux_word;
      out_valid_d   = 1'b1;
      sel_d         = winner;
      last_served_d = winner;
    end else if (accept) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      xfer_count_d = xfer_count_q + count_width'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      sel_q         <= 1'b0;
      last_served_q <= REQ1;
      xfer_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      sel_q         <= sel_d;
      last_served_q <= last_served_d;
      xfer_count_q  <= xfer_count_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign sel        = sel_q;
  assign xfer_count = xfer_count_q;

endmodule

// File: tb/tb_word_bus_arbiter.sv
// Scoreboard bench for word_bus_arbiter: directed scenarios plus random traffic
// against a transaction-level reference model.
module tb_word_bus_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0, req1;
  logic [31:0] data0, data1;
  logic        grant0, grant1;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic        sel;
  logic [7:0]  xfer_count;

  int checks;
  int errors;

  // Expected words in the order the consumer should see them: {winner, data}.
  logic [32:0] exp_q[$];

  // Reference model state: stage occupancy, last served requester, accepted count.
  bit          full_m;
  bit          last_m;
  logic [7:0]  cnt_m;
  logic [7:0]  last_cnt;

  word_bus_arbiter #(
    .word_size  (32),
    .count_width(8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0),
    .data0     (data0),
    .grant0    (grant0),
    .req1      (req1),
    .data1     (data1),
    .grant1    (grant1),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .sel       (sel),
    .xfer_count(xfer_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check grants/state, advance model.
  task automatic cycle(input logic r0, input logic r1, input logic [31:0] d0,
                       input logic [31:0] d1, input logic rdy);
    bit accept, can_load, w, any;
    @(negedge clk);
    req0 = r0; req1 = r1; data0 = d0; data1 = d1; out_ready = rdy;
    #1;
    accept   = full_m && rdy;
    can_load = !full_m || rdy;
    any      = r0 || r1;
    if (r0 && r1) w = !last_m;
    else          w = r1;
    check("grant0", 32'(grant0), 32'(can_load && any && !w));
    check("grant1", 32'(grant1), 32'(can_load && any && w));
    check("out_valid", 32'(out_valid), 32'(full_m));
    check("xfer_count", 32'(xfer_count), 32'(cnt_m));
    last_cnt = xfer_count;
    if (can_load && any) begin
      exp_q.push_back({w, w ? d1 : d0});
      last_m = w;
      full_m = 1'b1;
    end else if (accept) begin
      full_m = 1'b0;
    end
    if (accept) cnt_m = cnt_m + 8'd1;
  endtask

  // Asynchronous reset asserted mid-cycle, checked immediately, released after a posedge.
  task automatic do_reset();
    @(negedge clk);
    #3;
    req0 = 1'b1; req1 = 1'b1; out_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    check("rst_grant0", 32'(grant0), 32'd0);
    check("rst_grant1", 32'(grant1), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_xfer_count", 32'(xfer_count), 32'd0);
    full_m = 1'b0; last_m = 1'b1; cnt_m = 8'd0;
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: every accepted output word must match the head of the scoreboard.
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word actual=%h required=none", out_data);
        end else begin
          e = exp_q.pop_front();
          check("out_data", out_data, e[31:0]);
          check("sel", 32'(sel), 32'(e[32]));
        end
      end
    end
  end

  initial begin
    checks = 0; errors = 0;
    full_m = 1'b0; last_m = 1'b1; cnt_m = 8'd0; last_cnt = 8'd0;
    rst_n = 1'b1;
    req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0; out_ready = 1'b0;

    // Reset with both requests pending, then fairness from reset.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b1, 32'hAAAA_AAAA, 32'hBBBB_BBBB, 1'b1);
      check("fair_grant0", 32'(grant0), 32'((i % 2) == 0));
    end

    // Single requester latency and drain.
    do_reset();
    cycle(1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b1);
    check("single_grant0", 32'(grant0), 32'd1);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_data", out_data, 32'hDEAD_BEEF);
    check("single_sel", 32'(sel), 32'd0);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    check("single_drained", 32'(out_valid), 32'd0);
    check("single_count", 32'(xfer_count), 32'd1);

    // Backpressure holds the word and blocks grants.
    cycle(1'b0, 1'b1, 32'h0, 32'h0000_1234, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0, 32'hCAFE_0000, 32'h0, 1'b0);
      check("bp_hold_data", out_data, 32'h0000_1234);
      check("bp_no_grant", 32'(grant0), 32'd0);
    end
    cycle(1'b1, 1'b0, 32'hCAFE_0000, 32'h0, 1'b1);
    check("bp_release_grant0", 32'(grant0), 32'd1);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    check("bp_next_data", out_data, 32'hCAFE_0000);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

    // Counter wrap after 256 accepted transfers.
    do_reset();
    for (int i = 0; i < 257; i++) begin
      cycle(1'b1, 1'b0, 32'h1000_0000 + 32'(i), 32'h0, 1'b1);
    end
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    check("wrap_count", 32'(last_cnt), 32'd0);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

    // Async reset while the holding stage is full.
    do_reset();
    cycle(1'b1, 1'b0, 32'h5555_5555, 32'h0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    check("pre_reset_valid", 32'(out_valid), 32'd1);
    do_reset();

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
            1'($urandom_range(0, 9) < 7));
    end
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
